digit_bbox_detect: RTL and testbench

- Upstream stage of the digit recognition block. Scans the binarized pixel stream, finds the bounding box of foreground (white) pixels inside a region of interest, and publishes it once per frame.
- Also generates the 3-bit frame phase counter `frame_cnt` that the recognition stage uses to schedule its capture, measure and read frames.
- Horizontal runs shorter than a minimum length are treated as noise and do not contribute to the box.

---
 rtl/digit_bbox_detect.sv | 139 +++++++++++++
 tb/tb_digit_bbox_detect.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/digit_bbox_detect.sv
// Bounding-box detector for the digit recognition path: tracks the extent of
// qualifying white runs inside the ROI and publishes the box once per frame.
module digit_bbox_detect #(
  parameter logic [11:0] H_MIN     = 12'd0,
  parameter logic [11:0] H_MAX     = 12'd639,
  parameter logic [11:0] V_MIN     = 12'd0,
  parameter logic [11:0] V_MAX     = 12'd479,
  parameter logic [3:0]  MIN_RUN   = 4'd3,
  parameter logic [2:0]  FRAME_MAX = 3'd3
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic [23:0] din,
  input  logic        i_de,
  input  logic        i_vsync,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  output logic [11:0] hcount_l,
  output logic [11:0] hcount_r,
  output logic [11:0] vcount_l,
  output logic [11:0] vcount_r,
  output logic        bbox_valid,
  output logic [2:0]  frame_cnt
);

  logic        vsync_q;
  logic [3:0]  run_cnt_q, run_cnt_d;
  logic        found_q, found_d;
  logic [11:0] min_h_q, min_h_d, max_h_q, max_h_d;
  logic [11:0] min_v_q, min_v_d, max_v_q, max_v_d;
  logic [11:0] hcount_l_q, hcount_l_d, hcount_r_q, hcount_r_d;
  logic [11:0] vcount_l_q, vcount_l_d, vcount_r_q, vcount_r_d;
  logic        bbox_valid_q, bbox_valid_d;
  logic [2:0]  frame_cnt_q, frame_cnt_d;

  logic        vs_rise, in_roi, white, qual;
  logic [11:0] run_left;

  // Unsigned a >= b via borrow, so ROI bounds at 0 never form a constant compare.
  function automatic logic ge12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return ~diff[12];
  endfunction

  assign vs_rise  = i_vsync & ~vsync_q;
  assign in_roi   = i_de & ge12(hcount, H_MIN) & ge12(H_MAX, hcount)
                         & ge12(vcount, V_MIN) & ge12(V_MAX, vcount);
  assign white    = in_roi & (din == 24'hFFFFFF);
  assign qual     = white & (({1'b0, run_cnt_q} + 5'd1) >= {1'b0, MIN_RUN});
  // Left edge of the run whose MIN_RUN-th pixel is at hcount.
  assign run_left = hcount - {8'd0, MIN_RUN - 4'd1};

  always_comb begin
    run_cnt_d    = run_cnt_q;
    found_d      = found_q;
    min_h_d      = min_h_q;
    max_h_d      = max_h_q;
    min_v_d      = min_v_q;
    max_v_d      = max_v_q;
    hcount_l_d   = hcount_l_q;
    hcount_r_d   = hcount_r_q;
    vcount_l_d   = vcount_l_q;
    vcount_r_d   = vcount_r_q;
    bbox_valid_d = bbox_valid_q;
    frame_cnt_d  = frame_cnt_q;

    if (vs_rise) begin
      if (found_q) begin
        hcount_l_d   = min_h_q;
        hcount_r_d   = max_h_q;
        vcount_l_d   = min_v_q;
        vcount_r_d   = max_v_q;
        bbox_valid_d = 1'b1;
      end else begin
        bbox_valid_d = 1'b0;
      end
      run_cnt_d   = 4'd0;
      found_d     = 1'b0;
      min_h_d     = 12'hFFF;
      max_h_d     = 12'd0;
      min_v_d     = 12'hFFF;
      max_v_d     = 12'd0;
      frame_cnt_d = (frame_cnt_q == FRAME_MAX) ? 3'd0 : frame_cnt_q + 3'd1;
    end else begin
      if (white)
        run_cnt_d = (run_cnt_q >= MIN_RUN) ? MIN_RUN : run_cnt_q + 4'd1;
      else
        run_cnt_d = 4'd0;
      if (qual) begin
        if (run_left < min_h_q) min_h_d = run_left;
        if (hcount > max_h_q)   max_h_d = hcount;
        if (vcount < min_v_q)   min_v_d = vcount;
        if (vcount > max_v_q)   max_v_d = vcount;
        found_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q      <= 1'b1;
      run_cnt_q    <= 4'd0;
      found_q      <= 1'b0;
      min_h_q      <= 12'hFFF;
      max_h_q      <= 12'd0;
      min_v_q      <= 12'hFFF;
      max_v_q      <= 12'd0;
      hcount_l_q   <= 12'd0;
      hcount_r_q   <= 12'd0;
      vcount_l_q   <= 12'd0;
      vcount_r_q   <= 12'd0;
      bbox_valid_q <= 1'b0;
      frame_cnt_q  <= 3'd0;
    end else begin
      vsync_q      <= i_vsync;
      run_cnt_q    <= run_cnt_d;
      found_q      <= found_d;
      min_h_q      <= min_h_d;
      max_h_q      <= max_h_d;
      min_v_q      <= min_v_d;
      max_v_q      <= max_v_d;
      hcount_l_q   <= hcount_l_d;
      hcount_r_q   <= hcount_r_d;
      vcount_l_q   <= vcount_l_d;
      vcount_r_q   <= vcount_r_d;
      bbox_valid_q <= bbox_valid_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign hcount_l   = hcount_l_q;
  assign hcount_r   = hcount_r_q;
  assign vcount_l   = vcount_l_q;
  assign vcount_r   = vcount_r_q;
  assign bbox_valid = bbox_valid_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_digit_bbox_detect.sv
// Scoreboard bench for digit_bbox_detect: stimulus pushes the box expected after
// each frame; a monitor pops it on every vsync rise and holds it between rises.
module tb_digit_bbox_detect;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic [23:0] din;
  logic        i_de;
  logic        i_vsync;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
  logic        bbox_valid;
  logic [2:0]  frame_cnt;

  typedef struct packed {
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] t;
    logic [11:0] b;
    logic        v;
    logic [2:0]  fc;
  } box_t;

  box_t exp_q[$];
  box_t cur;
  int   checks   = 0;
  int   failures = 0;

  always #5 pixel_clk = ~pixel_clk;

  digit_bbox_detect dut (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .din        (din),
    .i_de       (i_de),
    .i_vsync    (i_vsync),
    .hcount     (hcount),
    .vcount     (vcount),
    .hcount_l   (hcount_l),
    .hcount_r   (hcount_r),
    .vcount_l   (vcount_l),
    .vcount_r   (vcount_r),
    .bbox_valid (bbox_valid),
    .frame_cnt  (frame_cnt)
  );

  function automatic box_t mk(input int l, input int r, input int t, input int b,
                              input logic v, input int fc);
    box_t x;
    x.l = l[11:0]; x.r = r[11:0]; x.t = t[11:0]; x.b = b[11:0];
    x.v = v; x.fc = fc[2:0];
    return x;
  endfunction

  // Monitor: outputs must equal the current expected box every cycle; each
  // vsync rise advances to the next scoreboard entry.
  initial begin : monitor
    logic vs_prev;
    logic rise;
    box_t got;
    vs_prev = 1'b1;
    cur     = '0;
    forever begin
      @(posedge pixel_clk);
      rise    = reset_n && i_vsync && !vs_prev;
      vs_prev = reset_n ? i_vsync : 1'b1;
      #1;
      if (rise) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_frame: vsync rise with empty scoreboard at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      got = {hcount_l, hcount_r, vcount_l, vcount_r, bbox_valid, frame_cnt};
      checks++;
      if (got !== cur) begin
        failures++;
        if (failures <= 20)
          $display("FAIL box@%0t: got l=%0d r=%0d t=%0d b=%0d v=%0b fc=%0d, need l=%0d r=%0d t=%0d b=%0d v=%0b fc=%0d",
                   $time, got.l, got.r, got.t, got.b, got.v, got.fc,
                   cur.l, cur.r, cur.t, cur.b, cur.v, cur.fc);
      end
    end
  end

  task automatic step(input logic de, input logic w, input int h, input int v, input logic vs);
    @(negedge pixel_clk);
    i_de    = de;
    din     = w ? 24'hFFFFFF : 24'hFFFFFE;
    hcount  = h[11:0];
    vcount  = v[11:0];
    i_vsync = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic run(input int h0, input int len, input int v);
    for (int i = 0; i < len; i++) step(1'b1, 1'b1, h0 + i, v, 1'b0);
    idle(1);
  endtask

  task automatic vs_pulse();
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    idle(3);
  endtask

  task automatic rect_frame();
    for (int v = 200; v <= 259; v++) begin
      for (int h = 95; h <= 155; h++)
        step(1'b1, (h >= 100 && h <= 149), h, v, 1'b0);
      idle(1);
    end
  endtask

  initial begin : stim
    reset_n = 1'b0;
    i_vsync = 1'b1;
    i_de    = 1'b0;
    din     = 24'd0;
    hcount  = 12'd0;
    vcount  = 12'd0;
    repeat (4) @(negedge pixel_clk);
    reset_n = 1'b1;
    repeat (5) step(1'b0, 1'b0, 0, 0, 1'b1);
    idle(3);

    // Frame A: rectangle 100..149 x 200..259
    rect_frame();
    exp_q.push_back(mk(100, 149, 200, 259, 1'b1, 1));
    vs_pulse();

    // Frame B: rectangle plus 2-pixel noise runs and a run beyond H_MAX
    run(10, 2, 10);
    rect_frame();
    run(600, 2, 470);
    run(700, 10, 300);
    step(1'b1, 1'b1, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1, 0, 1'b0);
    exp_q.push_back(mk(100, 149, 200, 259, 1'b1, 2));
    // third white pixel of the run lands on the vsync rise and must be dropped
    step(1'b1, 1'b1, 2, 0, 1'b1);
    step(1'b1, 1'b1, 3, 0, 1'b1);
    step(1'b1, 1'b1, 4, 0, 1'b0);
    idle(3);

    // Frame C: nothing qualifies (the two pixels above are a fresh short run)
    idle(20);
    exp_q.push_back(mk(100, 149, 200, 259, 1'b0, 3));
    vs_pulse();

    // Frame D: exact-length run, H_MAX crossing, and a line gap splitting a run
    run(20, 5, 50);
    run(30, 3, 60);
    run(636, 10, 70);
    step(1'b1, 1'b1, 100, 80, 1'b0);
    step(1'b1, 1'b1, 101, 80, 1'b0);
    step(1'b0, 1'b1, 102, 80, 1'b0);
    step(1'b1, 1'b1, 102, 80, 1'b0);
    step(1'b1, 1'b1, 103, 80, 1'b0);
    idle(2);
    exp_q.push_back(mk(20, 639, 50, 70, 1'b1, 0));
    vs_pulse();

    // Frame E: single minimal run
    run(600, 3, 5);
    exp_q.push_back(mk(600, 602, 5, 5, 1'b1, 1));
    vs_pulse();
    idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
